// File: rtl/cgp_eval_pkg.sv
// Shared types and constants for the CGP fitness evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cgp_eval_pkg;

    localparam int DEF_N_IN   = 10;
    localparam int DEF_N_OUT  = 10;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } eval_state_t;

    // Worst case total is 2^n_in * n_out, which always fits in n_in plus
    // the bits needed to hold n_out.
    function automatic int err_width(input int n_in, input int n_out);
        return n_in + $clog2(n_out + 1);
    endfunction

endpackage

// File: rtl/cgp_evaluator_popcount.sv
// Combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   vec_i  in  W             bits to count
//   cnt_o  out $clog2(W+1)   number of set bits in vec_i
module popcount #(
    parameter int W = 10
) (
    input  logic [W-1:0]             vec_i,
    output logic [$clog2(W+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/cgp_evaluator.sv
// Sweeps all 2^N_IN vectors through a CGP circuit and counts output-bit errors.
// Latency: done pulses 1 + 2^N_IN*(SETTLE+1) cycles after start is accepted.
// Backpressure: none; start is only sampled in IDLE and is ignored otherwise.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin an evaluation (sampled in IDLE only)
//   busy         high while vectors are being applied
//   done         one-cycle pulse when err_count/perfect are final
//   cgp_in       registered vector driven to the CGP circuit inputs
//   cgp_out      CGP circuit outputs, same clock domain
//   exp_addr     expected-response memory address (mirrors cgp_in)
//   exp_data     expected response, synchronous read with 1-cycle latency
//   err_count    total mismatching output bits of the last completed run
//   perfect      err_count == 0, valid from the done cycle onward
module cgp_evaluator
    import cgp_eval_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE   // must be >= 1 to cover the memory latency
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_IN-1:0]                      cgp_in,
    input  logic [N_OUT-1:0]                     cgp_out,
    output logic [N_IN-1:0]                      exp_addr,
    input  logic [N_OUT-1:0]                     exp_data,
    output logic [err_width(N_IN, N_OUT)-1:0]    err_count,
    output logic                                 perfect
);

    localparam int ERR_W = err_width(N_IN, N_OUT);
    localparam int PC_W  = $clog2(N_OUT + 1);
    localparam int SW    = $clog2(SETTLE + 1);

    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);

    eval_state_t        state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [ERR_W-1:0]   acc_q, acc_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               perfect_q, perfect_d;

    logic [N_OUT-1:0]   mismatch;
    logic [PC_W-1:0]    mismatch_cnt;
    logic [ERR_W-1:0]   acc_sum;

    assign mismatch = cgp_out ^ exp_data;

    popcount #(
        .W (N_OUT)
    ) u_popcount (
        .vec_i (mismatch),
        .cnt_o (mismatch_cnt)
    );

    // Zero-extended add; the width guarantees no overflow for a full sweep.
    assign acc_sum = acc_q + ERR_W'(mismatch_cnt);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        acc_d     = acc_q;
        err_d     = err_q;
        perfect_d = perfect_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    vec_d    = '0;
                    settle_d = '0;
                    state_d  = APPLY;
                end
            end

            APPLY: begin
                busy = 1'b1;
                if (settle_q != SETTLE_C) begin
                    settle_d = settle_q + 1'b1;
                end else begin
                    // Last cycle of this vector's window: outputs and memory
                    // data have both had time to become valid.
                    acc_d    = acc_sum;
                    settle_d = '0;
                    if (vec_q == '1) begin
                        // Publish only the final total, never a partial sum.
                        err_d     = acc_sum;
                        perfect_d = (acc_sum == '0);
                        state_d   = DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            settle_q  <= '0;
            acc_q     <= '0;
            err_q     <= '0;
            perfect_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            perfect_q <= perfect_d;
        end
    end

    assign cgp_in    = vec_q;
    assign exp_addr  = vec_q;
    assign err_count = err_q;
    assign perfect   = perfect_q;

endmodule

// File: tb/tb_cgp_evaluator.sv
// Self-checking bench for cgp_evaluator: default-size instance plus a small
// (N_IN=4, N_OUT=3, SETTLE=1) instance, each driven by a behavioural CGP
// stand-in and expected-response memory.
module tb_cgp_evaluator;
    import cgp_eval_pkg::*;

    localparam int NI  = 10;
    localparam int NO  = 10;
    localparam int EW  = err_width(NI, NO);
    localparam int SNI = 4;
    localparam int SNO = 3;
    localparam int SEW = err_width(SNI, SNO);

    logic clk;
    logic rst_n;

    // Default-size instance
    logic            start_d, busy_d, done_d, perfect_d;
    logic [NI-1:0]   cgp_in_d, exp_addr_d;
    logic [NO-1:0]   cgp_out_d, exp_data_d;
    logic [EW-1:0]   err_count_d;

    // Small instance
    logic            start_s, busy_s, done_s, perfect_s;
    logic [SNI-1:0]  cgp_in_s, exp_addr_s;
    logic [SNO-1:0]  cgp_out_s, exp_data_s;
    logic [SEW-1:0]  err_count_s;
    logic [SNO-1:0]  mem_s [16];

    int mode;
    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];

    cgp_evaluator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_d),
        .busy      (busy_d),
        .done      (done_d),
        .cgp_in    (cgp_in_d),
        .cgp_out   (cgp_out_d),
        .exp_addr  (exp_addr_d),
        .exp_data  (exp_data_d),
        .err_count (err_count_d),
        .perfect   (perfect_d)
    );

    cgp_evaluator #(
        .N_IN   (SNI),
        .N_OUT  (SNO),
        .SETTLE (1)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .busy      (busy_s),
        .done      (done_s),
        .cgp_in    (cgp_in_s),
        .cgp_out   (cgp_out_s),
        .exp_addr  (exp_addr_s),
        .exp_data  (exp_data_s),
        .err_count (err_count_s),
        .perfect   (perfect_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CGP stand-in: 0 = identity, 1 = inverted, 2 = identity with out0 stuck at 0
    always_comb begin
        case (mode)
            0:       cgp_out_d = cgp_in_d;
            1:       cgp_out_d = ~cgp_in_d;
            default: cgp_out_d = cgp_in_d & 10'h3FE;
        endcase
    end

    // Identity expected memory, 1-cycle read latency
    always_ff @(posedge clk) exp_data_d <= exp_addr_d;

    assign cgp_out_s = cgp_in_s[SNO-1:0];
    always_ff @(posedge clk) exp_data_s <= mem_s[exp_addr_s];

    function automatic int model_err(input int m);
        int e;
        logic [NI-1:0] v;
        logic [NO-1:0] o;
        e = 0;
        for (int i = 0; i < (1 << NI); i++) begin
            v = NI'(i);
            case (m)
                0:       o = v;
                1:       o = ~v;
                default: o = v & 10'h3FE;
            endcase
            e += $countones(o ^ v);
        end
        return e;
    endfunction

    function automatic int model_err_s();
        int e;
        logic [SNI-1:0] a;
        e = 0;
        for (int i = 0; i < 16; i++) begin
            a = SNI'(i);
            e += $countones(a[SNO-1:0] ^ mem_s[i]);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // One full run on the default instance with start pulsed for one cycle.
    task automatic run_d(input string tag, input int m);
        int n;
        int e;
        mode = m;
        exp_q.push_back(model_err(m));
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0;
        chk({tag, "_busy_k1"}, 32'(busy_d), 32'd1);
        chk({tag, "_vec0_k1"}, 32'(cgp_in_d), 32'd0);
        n = 1;
        while (!done_d && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_d), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd3073);
        chk({tag, "_busy_at_done"}, 32'(busy_d), 32'd0);
        e = exp_q.pop_front();
        chk({tag, "_err_count"}, 32'(err_count_d), 32'(e));
        chk({tag, "_perfect"}, 32'(perfect_d), 32'(e == 0));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(done_d), 32'd0);
        chk({tag, "_err_hold"}, 32'(err_count_d), 32'(e));
    endtask

    initial begin
        int n;
        int e;

        rst_n   = 1'b0;
        start_d = 1'b0;
        start_s = 1'b0;
        mode    = 0;
        for (int i = 0; i < 16; i++) mem_s[i] = SNO'(i);
        // Five flipped bits at scattered addresses
        mem_s[1]  = mem_s[1]  ^ 3'b001;
        mem_s[6]  = mem_s[6]  ^ 3'b100;
        mem_s[9]  = mem_s[9]  ^ 3'b011;
        mem_s[15] = mem_s[15] ^ 3'b010;

        #12;
        chk("rst_busy",    32'(busy_d),      32'd0);
        chk("rst_done",    32'(done_d),      32'd0);
        chk("rst_cgp_in",  32'(cgp_in_d),    32'd0);
        chk("rst_err",     32'(err_count_d), 32'd0);
        chk("rst_perfect", 32'(perfect_d),   32'd0);
        chk("rst_s_busy",  32'(busy_s),      32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_d("ident", 0);
        run_d("invert", 1);
        run_d("stuck0", 2);

        // Start held high through a whole run: one done, restart only after it.
        mode = 1;
        exp_q.push_back(model_err(1));
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!done_d && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (!done_d && !busy_d) break;
        end
        chk("hold_done_seen", 32'(done_d), 32'd1);
        chk("hold_latency",   32'(n),      32'd3073);
        chk("hold_busy_done", 32'(busy_d), 32'd0);
        e = exp_q.pop_front();
        chk("hold_err_count", 32'(err_count_d), 32'(e));
        chk("hold_perfect",   32'(perfect_d),   32'(e == 0));
        @(posedge clk); #1;
        chk("hold_idle_busy", 32'(busy_d), 32'd0);
        chk("hold_idle_done", 32'(done_d), 32'd0);
        @(posedge clk); #1;
        chk("hold_restart_busy", 32'(busy_d),   32'd1);
        chk("hold_restart_vec",  32'(cgp_in_d), 32'd0);
        start_d = 1'b0;

        // Abort the restarted run at vector 100 with an asynchronous reset.
        n = 0;
        while (cgp_in_d != 10'd100 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_vec100", 32'(cgp_in_d), 32'd100);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     32'(busy_d),      32'd0);
        chk("abort_done",     32'(done_d),      32'd0);
        chk("abort_cgp_in",   32'(cgp_in_d),    32'd0);
        chk("abort_exp_addr", 32'(exp_addr_d),  32'd0);
        chk("abort_err",      32'(err_count_d), 32'd0);
        chk("abort_perfect",  32'(perfect_d),   32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_stays_idle", 32'(busy_d), 32'd0);

        run_d("rerun_invert", 1);

        // Small instance: SETTLE=1, 16 vectors of 2 cycles each.
        exp_q.push_back(model_err_s());
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        chk("small_busy_k1", 32'(busy_s), 32'd1);
        n = 1;
        while (!done_s && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("small_done_seen", 32'(done_s), 32'd1);
        chk("small_latency",   32'(n),      32'd33);
        e = exp_q.pop_front();
        chk("small_err_count", 32'(err_count_s), 32'(e));
        chk("small_err_five",  32'(err_count_s), 32'd5);
        chk("small_perfect",   32'(perfect_s),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
